// File: rtl/cmac_link_sequencer_if.sv
// Signal bundle between the CMAC link sequencer and the CMAC/GT core plus status registers.
// The master side is the sequencer; the slave side is the core/status logic.
interface cmac_link_sequencer_if;
  logic        gt_powergood;
  logic        stat_rx_aligned;
  logic        sys_reset;
  logic        gtwiz_reset_rx;
  logic        ctl_rx_enable;
  logic        ctl_tx_enable;
  logic        ctl_tx_send_rfi;
  logic        ctl_rsfec_enable;
  logic        link_up;
  logic [15:0] retry_count;
  logic [15:0] link_drop_count;
  logic [2:0]  fsm_state;

  modport master (
    input  gt_powergood,
    input  stat_rx_aligned,
    output sys_reset,
    output gtwiz_reset_rx,
    output ctl_rx_enable,
    output ctl_tx_enable,
    output ctl_tx_send_rfi,
    output ctl_rsfec_enable,
    output link_up,
    output retry_count,
    output link_drop_count,
    output fsm_state
  );

  modport slave (
    output gt_powergood,
    output stat_rx_aligned,
    input  sys_reset,
    input  gtwiz_reset_rx,
    input  ctl_rx_enable,
    input  ctl_tx_enable,
    input  ctl_tx_send_rfi,
    input  ctl_rsfec_enable,
    input  link_up,
    input  retry_count,
    input  link_drop_count,
    input  fsm_state
  );
endinterface

// File: rtl/cmac_link_sequencer.sv
// Bring-up/recovery sequencer for one CMAC 100G port: reset, power-good wait, alignment retries
// and debounced link-up. Define CMAC_FEC_FALLBACK_EN to toggle RS-FEC after repeated timeouts.
module cmac_link_sequencer #(
  parameter int unsigned FREQ_HZ              = 322265625,
  parameter bit          RSFEC                = 1'b1,
  parameter int unsigned SYS_RESET_CYCLES     = 100,
  parameter int unsigned RX_RESET_CYCLES      = 50,
  parameter int unsigned ALIGN_TIMEOUT_CYCLES = 3 * FREQ_HZ,
  parameter int unsigned LINK_DEBOUNCE_CYCLES = 1024,
  parameter int unsigned FEC_RETRIES          = 4
) (
  input logic                   clk,
  input logic                   resetn,
  cmac_link_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StSysReset  = 3'd0,
    StWaitPg    = 3'd1,
    StWaitAlign = 3'd2,
    StRxReset   = 3'd3,
    StDebounce  = 3'd4,
    StLinkUp    = 3'd5
  } state_e;

  localparam logic [31:0] SysLoad   = 32'(SYS_RESET_CYCLES);
  localparam logic [31:0] RxLoad    = 32'(RX_RESET_CYCLES);
  localparam logic [31:0] AlignLoad = 32'(ALIGN_TIMEOUT_CYCLES);
  localparam logic [31:0] DebLoad   = 32'(LINK_DEBOUNCE_CYCLES);

  // Asynchronous assertion, synchronous release.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  logic [3:0] pg_sync_q;
  logic [3:0] al_sync_q;
  logic       pg_s;
  logic       al_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_sync_q <= '0;
      al_sync_q <= '0;
    end else begin
      pg_sync_q <= {pg_sync_q[2:0], bus.gt_powergood};
      al_sync_q <= {al_sync_q[2:0], bus.stat_rx_aligned};
    end
  end

  assign pg_s = pg_sync_q[3];
  assign al_s = al_sync_q[3];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] retry_q, retry_d;
  logic [15:0] drop_q, drop_d;
  logic        sys_reset_q, gtwiz_q, rx_en_q, tx_en_q, link_q;

`ifdef CMAC_FEC_FALLBACK_EN
  logic       fec_q, fec_d;
  logic [2:0] attempt_q, attempt_d;
`else
  logic unused_fec_retries;
  assign unused_fec_retries = ^FEC_RETRIES;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == '0) ? '0 : timer_q - 32'd1;
    retry_d = retry_q;
    drop_d  = drop_q;
`ifdef CMAC_FEC_FALLBACK_EN
    fec_d     = fec_q;
    attempt_d = attempt_q;
`endif
    case (state_q)
      StSysReset: begin
        if (timer_q == '0) state_d = StWaitPg;
      end
      StWaitPg: begin
        if (pg_s) begin
          state_d = StWaitAlign;
          timer_d = AlignLoad;
        end
      end
      StWaitAlign: begin
        if (al_s) begin
          state_d = StDebounce;
          timer_d = DebLoad;
        end else if (timer_q == '0) begin
          state_d = StRxReset;
          timer_d = RxLoad;
          retry_d = sat_inc(retry_q);
`ifdef CMAC_FEC_FALLBACK_EN
          // New FEC mode takes effect while RX is held in reset.
          if (attempt_q + 3'd1 == 3'(FEC_RETRIES)) begin
            fec_d     = ~fec_q;
            attempt_d = '0;
          end else begin
            attempt_d = attempt_q + 3'd1;
          end
`endif
        end
      end
      StRxReset: begin
        if (timer_q == '0) begin
          state_d = StWaitAlign;
          timer_d = AlignLoad;
        end
      end
      StDebounce: begin
        if (!al_s) begin
          state_d = StWaitAlign;
          timer_d = AlignLoad;
        end else if (timer_q == '0) begin
          state_d = StLinkUp;
        end
      end
      StLinkUp: begin
        if (!al_s) begin
          state_d = StWaitAlign;
          timer_d = AlignLoad;
          drop_d  = sat_inc(drop_q);
        end
      end
      default: begin
        state_d = StSysReset;
        timer_d = SysLoad;
      end
    endcase

    // Power loss overrides everything, including counter updates of this cycle.
    if (!pg_s && state_q != StSysReset && state_q != StWaitPg) begin
      state_d = StSysReset;
      timer_d = SysLoad;
      retry_d = retry_q;
      drop_d  = drop_q;
`ifdef CMAC_FEC_FALLBACK_EN
      fec_d   = fec_q;
`endif
    end

`ifdef CMAC_FEC_FALLBACK_EN
    if ((state_d == StLinkUp || state_d == StSysReset) && state_d != state_q) attempt_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSysReset;
      timer_q     <= SysLoad;
      retry_q     <= '0;
      drop_q      <= '0;
      sys_reset_q <= 1'b1;
      gtwiz_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      tx_en_q     <= 1'b0;
      link_q      <= 1'b0;
`ifdef CMAC_FEC_FALLBACK_EN
      fec_q       <= RSFEC;
      attempt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      drop_q      <= drop_d;
      sys_reset_q <= (state_d == StSysReset);
      gtwiz_q     <= (state_d == StRxReset);
      rx_en_q     <= (state_d != StSysReset);
      tx_en_q     <= (state_d == StLinkUp);
      link_q      <= (state_d == StLinkUp);
`ifdef CMAC_FEC_FALLBACK_EN
      fec_q       <= fec_d;
      attempt_q   <= attempt_d;
`endif
    end
  end

  assign bus.sys_reset       = sys_reset_q;
  assign bus.gtwiz_reset_rx  = gtwiz_q;
  assign bus.ctl_rx_enable   = rx_en_q;
  assign bus.ctl_tx_enable   = tx_en_q;
  assign bus.ctl_tx_send_rfi = ~tx_en_q;
  assign bus.link_up         = link_q;
  assign bus.retry_count     = retry_q;
  assign bus.link_drop_count = drop_q;
  assign bus.fsm_state       = state_q;
`ifdef CMAC_FEC_FALLBACK_EN
  assign bus.ctl_rsfec_enable = fec_q;
`else
  assign bus.ctl_rsfec_enable = RSFEC;
`endif

endmodule
